wavepool_issue_arbiter: RTL
===========================

Name: wavepool_issue_arbiter

Overview:
- Round-robin issue arbiter for the 40-slot wavepool.
- Each cycle it picks one eligible wavefront among the 40 slots and extracts that slot's 35-bit entry from the flattened pool bus into a registered output stage with valid/ready handshake.
- It locks the granted wavefront out until the downstream stage releases it.
- Sits between the wavepool buffer and the issue/decode stage.

Parameters:
- NUM_WF, 40, number of wavefront slots.
- WFID_W, 6, width of wavefront id.
- ENTRY_W, 35, width of one pool entry.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  NUM_WF  per-slot "entry present and ready to issue".
- pool_entries  input  NUM_WF*ENTRY_W  flattened entries; slot i occupies bits [ENTRY_W*i+ENTRY_W-1 : ENTRY_W*i].
- halt  input  1  suppresses new grants; output stage still drains.
- out_ready  input  1  downstream accepts out_data this cycle.
- release_valid  input  1  downstream finished with a wavefront.
- release_wfid  input  WFID_W  id being released.
- grant_onehot  output  NUM_WF  combinational one-hot pop pulse to the pool in the grant cycle.
- out_valid  output  1  registered entry valid.
- out_data  output  ENTRY_W  registered granted entry.
- out_wfid  output  WFID_W  registered granted id.
- inflight  output  NUM_WF  registered lockout mask, for debug/flush logic.

Behaviour:
- Reset (rst==0 at edge): out_valid=0, out_data=0, out_wfid=0, inflight=0, rr_ptr=0. grant_onehot is 0 while rst==0.
- eligible = req_valid & ~inflight.
- can_load = ~out_valid | out_ready.
- grant_en = can_load & ~halt & (eligible != 0).
- Winner: the first eligible slot scanning upward from rr_ptr, wrapping 39 -> 0.
- grant_onehot = winner one-hot when grant_en, else 0. It depends only on current registers and inputs; there is no combinational path from out_data.
- On grant_en at edge:
  - out_valid <= 1, out_data <= winner slice, out_wfid <= winner.
  - inflight[winner] <= 1.
  - rr_ptr <= winner+1, or 0 when winner==39.
- Latency: grant in cycle t, data visible on out_* in cycle t+1.
- Back-to-back grants every cycle while out_ready=1.
- When out_valid & out_ready & ~grant_en: out_valid <= 0. out_data and out_wfid hold their last values.
- When out_valid & ~out_ready: all out_* hold and no grant occurs (stall).
- Release: release_valid with release_wfid < NUM_WF clears inflight[release_wfid] at the edge. The slot becomes eligible the next cycle, not the same cycle.
  - Release of an id >= 40 is ignored.
  - Release of a slot that is not inflight has no effect.
- Simultaneous release and grant: applied independently. A released slot cannot be the same-cycle winner because it was still inflight.
- rr_ptr advances only on grant. halt and stalls freeze it.
- Only one grant per cycle. grant_onehot has at most one bit set.
- Reset mid-stall: out_valid drops to 0 and inflight clears. The in-flight entry is lost; this is by design, since the pool is reset by the same signal.

Decomposition:
- Shared wavepool package: NUM_WF, WFID_W, ENTRY_W constants and a WFID_NONE value (6'd63).
- One natural sub-module: rr_prio_enc_40, a rotate-by-rr_ptr priority encoder returning the winner id and an any-valid flag.
- Slice extraction is an indexed part-select on winner inside the top module.

Test Plan:
1. Reset, then req_valid=all ones, out_ready=1, no releases:
   - grants 0,1,2,...,39 on consecutive cycles.
   - out_wfid follows one cycle later.
   - from cycle 40 on, grant_onehot stays 0 because all slots are inflight.
2. Round-robin wrap: rr_ptr=38 (after granting 37), eligible={3,38}, then release 37 and re-request:
   - grant 38, then 3, then 37.
   - out_data equals pool_entries[ENTRY_W*id +: ENTRY_W] each time.
3. Stall: grant slot 5, hold out_ready=0 for 4 cycles with slot 6 requesting:
   - out_wfid stays 5, out_valid stays 1, grant_onehot stays 0.
   - out_ready=1 gives grant 6 in that cycle and out_wfid=6 next cycle.
4. Release timing: slot 9 inflight and requesting, release_wfid=9 pulsed at cycle t:
   - no grant of 9 at t.
   - grant of 9 at t+1.
   - release_wfid=45 at any time leaves inflight unchanged.
5. halt=1 for 3 cycles with req_valid=0x3:
   - no grants, rr_ptr unchanged, the pending output drains.
   - halt=0 resumes with grant of slot 0.
6. Assert rst=0 while out_valid=1 and inflight=0xFF:
   - next cycle out_valid=0, inflight=0.
   - first grant after release of reset is the lowest requesting slot.

Source files
------------

// File: rtl/wavepool_issue_arbiter_pkg.sv
// Shared wavepool constants and small helpers used by the issue arbiter and its encoder.
package wavepool_issue_arbiter_pkg;

    localparam int NUM_WF  = 40;
    localparam int WFID_W  = 6;
    localparam int ENTRY_W = 35;

    localparam logic [WFID_W-1:0] WFID_NONE = 6'd63;

    // Next round-robin start position: one past the winner, wrapping at the last slot.
    function automatic logic [WFID_W-1:0] wrap_inc(input logic [WFID_W-1:0] id);
        return (id == WFID_W'(NUM_WF - 1)) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/wavepool_issue_arbiter_rr_prio_enc_40.sv
// Rotating priority encoder: first set bit of valid scanning upward from ptr, wrapping 39 -> 0.
module rr_prio_enc_40
    import wavepool_issue_arbiter_pkg::*;
(
    input  logic [NUM_WF-1:0] valid,
    input  logic [WFID_W-1:0] ptr,
    output logic [WFID_W-1:0] winner,
    output logic              hit
);

    logic [WFID_W-1:0] cand [NUM_WF];
    logic [NUM_WF-1:0] rot;

    // rot[k] is the request of the slot k positions after ptr (mod NUM_WF).
    generate
        for (genvar gi = 0; gi < NUM_WF; gi++) begin : g_rot
            logic [WFID_W:0] sum;
            assign sum      = {1'b0, ptr} + (WFID_W+1)'(gi);
            assign cand[gi] = (sum >= (WFID_W+1)'(NUM_WF)) ?
                              WFID_W'(sum - (WFID_W+1)'(NUM_WF)) : sum[WFID_W-1:0];
            assign rot[gi]  = valid[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner = WFID_NONE;
        hit    = 1'b0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (rot[i]) begin
                winner = cand[i];
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wavepool_issue_arbiter.sv
// Round-robin issue arbiter for the 40-slot wavepool: grants one eligible slot per cycle
// into a registered valid/ready output stage and locks it out until released downstream.
module wavepool_issue_arbiter
    import wavepool_issue_arbiter_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WF-1:0]           req_valid,
    input  logic [NUM_WF*ENTRY_W-1:0]   pool_entries,
    input  logic                        halt,
    input  logic                        out_ready,
    input  logic                        release_valid,
    input  logic [WFID_W-1:0]           release_wfid,
    output logic [NUM_WF-1:0]           grant_onehot,
    output logic                        out_valid,
    output logic [ENTRY_W-1:0]          out_data,
    output logic [WFID_W-1:0]           out_wfid,
    output logic [NUM_WF-1:0]           inflight
);

    logic [NUM_WF-1:0]  inflight_reg;
    logic [NUM_WF-1:0]  inflight_next;
    logic [NUM_WF-1:0]  eligible;
    logic [NUM_WF-1:0]  grant_mask;
    logic [NUM_WF-1:0]  release_mask;
    logic               out_valid_reg;
    logic [ENTRY_W-1:0] out_data_reg;
    logic [WFID_W-1:0]  out_wfid_reg;
    logic [WFID_W-1:0]  rr_ptr_reg;
    logic [WFID_W-1:0]  winner;
    logic [WFID_W-1:0]  winner_idx;
    logic [ENTRY_W-1:0] winner_entry;
    logic               hit;
    logic               can_load;
    logic               grant_en;

    assign eligible = req_valid & ~inflight_reg;

    rr_prio_enc_40 u_enc (
        .valid  (eligible),
        .ptr    (rr_ptr_reg),
        .winner (winner),
        .hit    (hit)
    );

    assign can_load = ~out_valid_reg | out_ready;
    assign grant_en = rst & can_load & ~halt & hit;

    // Release ids >= NUM_WF match no slot, so they fall out of the decode naturally.
    generate
        for (genvar gi = 0; gi < NUM_WF; gi++) begin : g_mask
            assign grant_mask[gi]   = grant_en && (winner == WFID_W'(gi));
            assign release_mask[gi] = release_valid && (release_wfid == WFID_W'(gi));
        end
    endgenerate

    assign grant_onehot  = grant_mask;
    assign inflight_next = (inflight_reg & ~release_mask) | grant_mask;

    // Keep the part-select in range when nothing is eligible.
    assign winner_idx   = hit ? winner : '0;
    assign winner_entry = pool_entries[ENTRY_W*winner_idx +: ENTRY_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_wfid_reg  <= '0;
            inflight_reg  <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            inflight_reg <= inflight_next;
            if (grant_en) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= winner_entry;
                out_wfid_reg  <= winner;
                rr_ptr_reg    <= wrap_inc(winner);
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_wfid  = out_wfid_reg;
    assign inflight  = inflight_reg;

endmodule
